// File: rtl/sound_pkg.sv
// sound_pkg: shared sound codes, default playback timing and scheduler state type
package sound_pkg;
  typedef logic [2:0] snd_code_t;
  localparam snd_code_t SND_NONE      = 3'd0;
  localparam snd_code_t SND_SELECT    = 3'd1;
  localparam snd_code_t SND_DESELECT  = 3'd2;
  localparam snd_code_t SND_MOVE      = 3'd3;
  localparam snd_code_t SND_CAPTURE   = 3'd4;
  localparam snd_code_t SND_ILLEGAL   = 3'd5;
  localparam snd_code_t SND_PROMOTE   = 3'd6;
  localparam snd_code_t SND_GAMEOVER  = 3'd7;
  localparam int unsigned PLAY_CYCLES_DEF = 32'd306250098;
  localparam int unsigned GAP_CYCLES_DEF  = 32'd1000000;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_PLAY, ST_GAP} state_t;
endpackage

// File: rtl/sound_event_scheduler_if.sv
// sound_event_scheduler_if: game-event inputs and player/status outputs of the sound scheduler
interface sound_event_scheduler_if import sound_pkg::*; #(parameter int DEPTH = 4);
  logic ev_valid;
  snd_code_t ev_code;
  logic mute;
  logic flush;
  logic play_sound;
  snd_code_t sound_code;
  logic busy;
  logic [$clog2(DEPTH):0] fifo_count;
  logic drop_pulse;
  modport master (output ev_valid, ev_code, mute, flush, input play_sound, sound_code, busy, fifo_count, drop_pulse);
  modport slave (input ev_valid, ev_code, mute, flush, output play_sound, sound_code, busy, fifo_count, drop_pulse);
endinterface

// File: rtl/sound_fifo.sv
// sound_fifo: small event FIFO with tail overwrite, registered pointers and count
module sound_fifo import sound_pkg::*; #(parameter int DEPTH = 4) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic push,
  input  logic ovr,
  input  logic pop,
  input  snd_code_t din,
  output snd_code_t dout,
  output logic [$clog2(DEPTH):0] count,
  output logic full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  snd_code_t mem_q [DEPTH];
  snd_code_t mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = din;
    else if (ovr) mem_d[wr_q - AW'(1)] = din;
    wr_d = clr ? '0 : wr_q + AW'(push);
    rd_d = clr ? '0 : rd_q + AW'(pop);
    cnt_d = clr ? '0 : cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  assign dout = mem_q[rd_q];
  assign count = cnt_q;
  assign full = cnt_q == CW'(DEPTH);
endmodule

// File: rtl/sound_event_scheduler.sv
// sound_event_scheduler: queues game sound events and paces one-cycle play pulses to the buzzer player
module sound_event_scheduler import sound_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int unsigned PLAY_CYCLES = PLAY_CYCLES_DEF,
  parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEF
) (
  input logic clk,
  input logic rstn,
  sound_event_scheduler_if.slave bus
);
  state_t state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic play_sound_q, play_sound_d, busy_q, busy_d, drop_pulse_q, drop_pulse_d;
  snd_code_t sound_code_q, sound_code_d, head;
  logic [$clog2(DEPTH):0] fifo_count;
  logic full, ev, hold, go;
  assign ev = bus.ev_valid && bus.ev_code != SND_NONE;
  assign hold = bus.mute || bus.flush;
  assign go = state_q == ST_IDLE && fifo_count != '0 && !hold;
  sound_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rstn(rstn),
    .clr(bus.flush),
    .push(ev && !hold && !full),
    .ovr(ev && !hold && full && bus.ev_code == SND_GAMEOVER),
    .pop(go),
    .din(bus.ev_code),
    .dout(head),
    .count(fifo_count),
    .full(full)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      ST_IDLE: state_d = go ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: begin
        state_d = ST_PLAY;
        cnt_d = PLAY_CYCLES - 1;
      end
      ST_PLAY: begin
        state_d = cnt_q != 0 ? ST_PLAY : GAP_CYCLES == 0 ? ST_IDLE : ST_GAP;
        cnt_d = cnt_q != 0 ? cnt_q - 32'd1 : GAP_CYCLES == 0 ? '0 : GAP_CYCLES - 1;
      end
      default: begin
        state_d = cnt_q != 0 ? ST_GAP : ST_IDLE;
        cnt_d = cnt_q != 0 ? cnt_q - 32'd1 : '0;
      end
    endcase
    if (bus.flush) begin
      state_d = ST_IDLE;
      cnt_d = '0;
    end
    play_sound_d = go;
    sound_code_d = go ? head : sound_code_q;
    busy_d = state_d != ST_IDLE;
    drop_pulse_d = ev && (hold || full);
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      play_sound_q <= 1'b0;
      sound_code_q <= SND_NONE;
      busy_q <= 1'b0;
      drop_pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      play_sound_q <= play_sound_d;
      sound_code_q <= sound_code_d;
      busy_q <= busy_d;
      drop_pulse_q <= drop_pulse_d;
    end
  end
  assign bus.play_sound = play_sound_q;
  assign bus.sound_code = sound_code_q;
  assign bus.busy = busy_q;
  assign bus.fifo_count = fifo_count;
  assign bus.drop_pulse = drop_pulse_q;
endmodule

// File: tb/tb_sound_event_scheduler.sv
// tb_sound_event_scheduler: directed table and sequence checks of the sound scheduler
module tb_sound_event_scheduler;
  import sound_pkg::*;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int total = 0;
  int bad = 0;
  int got_c[$], got_k[$], exp_c[$], exp_k[$];
  typedef struct packed {
    logic v;
    logic [2:0] c;
    logic p;
    logic [2:0] k;
    logic b;
    logic [2:0] n;
    logic d;
  } vec_t;
  vec_t vt [15];
  sound_event_scheduler_if #(.DEPTH(4)) bus ();
  sound_event_scheduler #(.DEPTH(4), .PLAY_CYCLES(20), .GAP_CYCLES(4)) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask
  task automatic next();
    @(negedge clk);
    bus.ev_valid = 1'b0;
    bus.flush = 1'b0;
  endtask
  task automatic all_zero(input string nm);
    chk({nm, " play"}, int'(bus.play_sound), 0);
    chk({nm, " code"}, int'(bus.sound_code), 0);
    chk({nm, " busy"}, int'(bus.busy), 0);
    chk({nm, " count"}, int'(bus.fifo_count), 0);
    chk({nm, " drop"}, int'(bus.drop_pulse), 0);
  endtask
  task automatic ev(input int code);
    bus.ev_valid = 1'b1;
    bus.ev_code = 3'(code);
  endtask
  task automatic watch(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      if (bus.play_sound) begin
        got_c.push_back(base + i);
        got_k.push_back(int'(bus.sound_code));
      end
      next();
    end
  endtask
  task automatic expect_pulses(input string nm);
    chk({nm, " pulse count"}, got_c.size(), exp_c.size());
    for (int i = 0; i < got_c.size() && i < exp_c.size(); i++) begin
      chk($sformatf("%s pulse%0d cycle", nm, i), got_c[i], exp_c[i]);
      chk($sformatf("%s pulse%0d code", nm, i), got_k[i], exp_k[i]);
    end
    got_c.delete();
    got_k.delete();
    exp_c.delete();
    exp_k.delete();
  endtask
  task automatic apply_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      chk($sformatf("row%0d play", i), int'(bus.play_sound), int'(vt[i].p));
      chk($sformatf("row%0d code", i), int'(bus.sound_code), int'(vt[i].k));
      chk($sformatf("row%0d busy", i), int'(bus.busy), int'(vt[i].b));
      chk($sformatf("row%0d count", i), int'(bus.fifo_count), int'(vt[i].n));
      chk($sformatf("row%0d drop", i), int'(bus.drop_pulse), int'(vt[i].d));
      bus.ev_valid = vt[i].v;
      bus.ev_code = vt[i].c;
      next();
    end
  endtask
  initial begin
    vt[0]  = '{1'b1, 3'd3, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0};
    vt[1]  = '{1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b0};
    vt[2]  = '{1'b0, 3'd0, 1'b1, 3'd3, 1'b1, 3'd0, 1'b0};
    vt[3]  = '{1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 3'd0, 1'b0};
    vt[4]  = '{1'b1, 3'd1, 1'b0, 3'd3, 1'b0, 3'd0, 1'b0};
    vt[5]  = '{1'b1, 3'd2, 1'b0, 3'd3, 1'b0, 3'd1, 1'b0};
    vt[6]  = '{1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 3'd1, 1'b0};
    vt[7]  = '{1'b1, 3'd4, 1'b0, 3'd1, 1'b1, 3'd2, 1'b0};
    vt[8]  = '{1'b1, 3'd5, 1'b0, 3'd1, 1'b1, 3'd3, 1'b0};
    vt[9]  = '{1'b1, 3'd6, 1'b0, 3'd1, 1'b1, 3'd4, 1'b0};
    vt[10] = '{1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 3'd4, 1'b1};
    vt[11] = '{1'b1, 3'd7, 1'b0, 3'd1, 1'b1, 3'd4, 1'b0};
    vt[12] = '{1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 3'd4, 1'b1};
    vt[13] = '{1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 3'd4, 1'b0};
    vt[14] = '{1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 3'd4, 1'b0};
    bus.ev_valid = 1'b0;
    bus.ev_code = 3'd0;
    bus.mute = 1'b0;
    bus.flush = 1'b0;
    repeat (3) @(negedge clk);
    all_zero("reset");
    rstn = 1'b1;
    next();
    next();
    // single event: pulse two cycles after the event, busy through play and gap
    apply_rows(0, 3);
    for (int c = 4; c < 30; c++) begin
      chk($sformatf("single c%0d busy", c), int'(bus.busy), c <= 26 ? 1 : 0);
      chk($sformatf("single c%0d play", c), int'(bus.play_sound), 0);
      next();
    end
    chk("single code kept", int'(bus.sound_code), 3);
    // overflow: 6 dropped, 7 overwrites tail, code 0 ignored
    apply_rows(4, 14);
    watch(11, 125);
    exp_c = '{28, 54, 80, 106};
    exp_k = '{2, 3, 4, 7};
    expect_pulses("overflow");
    chk("overflow idle busy", int'(bus.busy), 0);
    // back-to-back
    ev(1);
    next();
    ev(4);
    next();
    watch(2, 55);
    exp_c = '{2, 28};
    exp_k = '{1, 4};
    expect_pulses("b2b");
    chk("b2b idle busy", int'(bus.busy), 0);
    // flush mid-play with two queued
    ev(1);
    next();
    ev(2);
    next();
    ev(3);
    watch(2, 6);
    chk("flush pre count", int'(bus.fifo_count), 2);
    chk("flush pre busy", int'(bus.busy), 1);
    bus.flush = 1'b1;
    next();
    chk("flush busy", int'(bus.busy), 0);
    chk("flush count", int'(bus.fifo_count), 0);
    chk("flush play", int'(bus.play_sound), 0);
    watch(9, 40);
    exp_c = '{2};
    exp_k = '{1};
    expect_pulses("flush");
    chk("flush code kept", int'(bus.sound_code), 1);
    // mute held across idle with two queued
    ev(5);
    next();
    ev(6);
    next();
    ev(2);
    watch(2, 8);
    bus.mute = 1'b1;
    watch(10, 20);
    chk("mute count", int'(bus.fifo_count), 2);
    chk("mute busy", int'(bus.busy), 0);
    ev(3);
    next();
    chk("mute drop", int'(bus.drop_pulse), 1);
    chk("mute count kept", int'(bus.fifo_count), 2);
    next();
    watch(32, 8);
    exp_c = '{2};
    exp_k = '{5};
    expect_pulses("muted");
    bus.mute = 1'b0;
    watch(40, 60);
    exp_c = '{41, 67};
    exp_k = '{6, 2};
    expect_pulses("unmute");
    // asynchronous reset during play
    ev(4);
    next();
    ev(7);
    next();
    watch(2, 4);
    rstn = 1'b0;
    #1;
    all_zero("async reset");
    next();
    rstn = 1'b1;
    watch(7, 40);
    exp_c = '{2};
    exp_k = '{4};
    expect_pulses("reset");
    chk("reset count", int'(bus.fifo_count), 0);
    chk("reset busy", int'(bus.busy), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
